// File: rtl/constraint_12_gen.sv
// Enumerates every WIDTH-bit value except FORBID from a seed, one full wrap per pass; CONSTRAINT_GEN_LFSR_EN selects LFSR order.
// Latency: first value the cycle after start (one extra bubble cycle if seed==FORBID).
// Backpressure: out_data/out_valid hold while out_ready is low; the FORBID bubble advances regardless.
module constraint_12_gen #(
   parameter int               WIDTH  = 22,
   parameter logic [WIDTH-1:0] FORBID = 22'h265f13
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] seed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] cur_nxt;
   logic [WIDTH-1:0] seed_q;
   logic [WIDTH-1:0] load_val;
   logic             load;
   logic             advance;
   logic             accept;

   function automatic logic [WIDTH-1:0] next_val(input logic [WIDTH-1:0] v);
`ifdef CONSTRAINT_GEN_LFSR_EN
      return {v[WIDTH-2:0], v[WIDTH-1] ^ v[WIDTH-2]};
`else
      return v + WIDTH'(1);
`endif
   endfunction

   // The LFSR locks up at zero, so a zero seed is promoted to 1 and that becomes the wrap reference.
`ifdef CONSTRAINT_GEN_LFSR_EN
   assign load_val = (seed == '0) ? WIDTH'(1) : seed;
`else
   assign load_val = seed;
`endif

   assign out_data = cur;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      advance   = 1'b0;
      load      = 1'b0;
      cur_nxt   = next_val(cur);
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy      = 1'b1;
            out_valid = (cur != FORBID);
            accept    = out_valid && out_ready;
            advance   = (cur == FORBID) || accept;
            // Wrap-complete: the next candidate would repeat the latched seed.
            if (advance && (cur_nxt == seed_q)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur    <= '0;
         count  <= '0;
         seed_q <= '0;
      end else if (load) begin
         cur    <= load_val;
         seed_q <= load_val;
         count  <= '0;
      end else begin
         if (advance) begin
            cur <= cur_nxt;
         end
         if (accept) begin
            count <= count + WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_constraint_12_gen.sv
// Randomized scoreboard bench for constraint_12_gen: 22-bit instance for sequencing/handshake, 8-bit instance for full-wrap/DONE.
module tb_constraint_12_gen;

   localparam logic [21:0] FORBID = 22'h265f13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [21:0] seed = '0;
   logic        out_ready = 1'b0;
   logic        out_valid;
   logic [21:0] out_data;
   logic        busy;
   logic        done;
   logic [21:0] count;

   constraint_12_gen u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .seed      (seed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done),
      .count     (count)
   );

   logic       s_rst = 1'b1;
   logic       s_start = 1'b0;
   logic [7:0] s_seed = '0;
   logic       s_ready = 1'b0;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_busy;
   logic       s_done;
   logic [7:0] s_count;

   constraint_12_gen #(.WIDTH(8), .FORBID(8'h13)) u_small (
      .clk       (clk),
      .rst       (s_rst),
      .start     (s_start),
      .seed      (s_seed),
      .out_valid (s_valid),
      .out_ready (s_ready),
      .out_data  (s_data),
      .busy      (s_busy),
      .done      (s_done),
      .count     (s_count)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [21:0] exp_q[$];
   int unsigned acc = 0;
   logic [7:0]  s_q[$];
   int unsigned s_acc = 0;
   logic        hold_prev = 1'b0;
   logic [21:0] hold_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference successor: plain modular arithmetic, or the tap rule in the LFSR build.
   function automatic logic [21:0] mnext(input logic [21:0] v);
`ifdef CONSTRAINT_GEN_LFSR_EN
      return {v[20:0], v[21] ^ v[20]};
`else
      return 22'((int'(v) + 1) % (1 << 22));
`endif
   endfunction

   task automatic load_expect(input logic [21:0] sd, input int n);
      logic [21:0] v;
      logic [21:0] first;
      v = sd;
`ifdef CONSTRAINT_GEN_LFSR_EN
      if (v == 22'd0) v = 22'd1;
`endif
      first = v;
      for (int k = 0; k < n; k++) begin
         if (v != FORBID) exp_q.push_back(v);
         v = mnext(v);
         if (v == first) break;
      end
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         chk("count_vs_accepts", {42'd0, count}, 64'(acc));
         if (hold_prev) chk("held_data_stable", {42'd0, out_data}, {42'd0, hold_data});
         if (out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_value: got %0h expected none", out_data);
            end else begin
               chk("out_data", {42'd0, out_data}, {42'd0, exp_q.pop_front()});
            end
            acc++;
         end
      end else if (hold_prev) begin
         chk("held_valid_dropped", {63'd0, out_valid}, 64'd1);
      end
      hold_prev = out_valid && !out_ready && !rst;
      hold_data = out_data;
   end

   always @(negedge clk) begin
      if (!s_rst && s_valid) begin
         chk("s_count_vs_accepts", {56'd0, s_count}, 64'(s_acc));
         if (s_ready) begin
            if (s_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL s_unexpected_value: got %0h expected none", s_data);
            end else begin
               chk("s_out_data", {56'd0, s_data}, {56'd0, s_q.pop_front()});
            end
            s_acc++;
         end
      end
   end

   task automatic check_idle_zero(input string tag);
      chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
      chk({tag, "_busy"},  {63'd0, busy}, 64'd0);
      chk({tag, "_done"},  {63'd0, done}, 64'd0);
      chk({tag, "_count"}, {42'd0, count}, 64'd0);
      chk({tag, "_data"},  {42'd0, out_data}, 64'd0);
   endtask

   task automatic run_pass(input logic [21:0] sd, input int cycles, input bit rand_ready, input bit spurious);
      exp_q.delete();
      acc = 0;
      load_expect(sd, cycles + 4);
      seed = sd;
      start = 1'b1;
      out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
      step();
      start = 1'b0;
      seed = 22'($urandom);
      chk("first_valid", {63'd0, out_valid}, {63'd0, (sd != FORBID)});
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      if (sd == FORBID) begin
         step();
         chk("valid_after_bubble", {63'd0, out_valid}, 64'd1);
         chk("data_after_bubble", {42'd0, out_data}, {42'd0, 22'h265f14});
      end
      for (int c = 0; c < cycles; c++) begin
         if (rand_ready) out_ready = ($urandom % 3) != 0;
         if (spurious && c == cycles / 2) begin
            start = 1'b1;
            seed = 22'($urandom);
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
      rst = 1'b1;
      step();
      check_idle_zero("midrun_rst");
      rst = 1'b0;
      out_ready = 1'b0;
      exp_q.delete();
      acc = 0;
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      check_idle_zero("reset");

      rst = 1'b1;
      start = 1'b1;
      seed = 22'h000005;
      step();
      rst = 1'b0;
      start = 1'b0;
      step();
      chk("rst_start_busy", {63'd0, busy}, 64'd0);
      chk("rst_start_valid", {63'd0, out_valid}, 64'd0);

      run_pass(22'h265f10, 12, 1'b0, 1'b0);
      run_pass(22'h3ffffe, 12, 1'b1, 1'b0);
      run_pass(FORBID, 10, 1'b1, 1'b0);
      run_pass(22'h000000, 10, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         logic [21:0] sd;
         sd = (i % 2 == 0) ? FORBID - 22'($urandom % 4) : 22'($urandom);
         run_pass(sd, 30 + int'($urandom % 40), 1'b1, 1'b1);
      end

`ifndef CONSTRAINT_GEN_LFSR_EN
      s_rst = 1'b1;
      step();
      s_rst = 1'b0;
      step();
      for (int k = 0; k < 256; k++) if (k != 8'h13) s_q.push_back(8'(k));
      s_acc = 0;
      s_seed = 8'h00;
      s_start = 1'b1;
      s_ready = 1'b1;
      step();
      s_start = 1'b0;
      begin
         int t;
         t = 0;
         while (!s_done && t < 600) begin
            step();
            t++;
         end
      end
      chk("s_done_reached", {63'd0, s_done}, 64'd1);
      chk("s_count_final", {56'd0, s_count}, 64'd255);
      chk("s_all_values_seen", 64'(s_q.size()), 64'd0);
      chk("s_valid_in_done", {63'd0, s_valid}, 64'd0);
      chk("s_busy_in_done", {63'd0, s_busy}, 64'd0);
      step();
      chk("s_count_held", {56'd0, s_count}, 64'd255);

      s_q.delete();
      for (int k = 0; k < 20; k++) s_q.push_back(8'(8'hF0 + k));
      s_acc = 0;
      s_seed = 8'hF0;
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      chk("s_restart_count", {56'd0, s_count}, 64'd0);
      chk("s_restart_busy", {63'd0, s_busy}, 64'd1);
      chk("s_restart_data", {56'd0, s_data}, 64'hF0);
      repeat (10) step();
      s_rst = 1'b1;
      step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
